// File: rtl/sram_syn_pkg.sv
// Shared types and helpers for the synaptic SRAM read-modify-write controller.
package sram_syn_pkg;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

  localparam logic OP_READ   = 1'b0;
  localparam logic OP_UPDATE = 1'b1;

  function automatic int lanes_of(input int dw, input int ww);
    return dw / ww;
  endfunction

endpackage

// File: rtl/syn_lane_update.sv
// One signed weight lane: old + delta under mask.
// SYN_WEIGHT_SAT_EN selects saturating add; otherwise the add wraps modulo 2^W.
module syn_lane_update #(
  parameter int W = 8
) (
  input  logic [W-1:0] old,
  input  logic [W-1:0] delta,
  input  logic         mask,
  output logic [W-1:0] new_wt
);

  logic [W-1:0] sum;
  logic [W-1:0] res;

  assign sum = old + delta;

`ifdef SYN_WEIGHT_SAT_EN
  logic ovf;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf = (old[W-1] == delta[W-1]) && (sum[W-1] != old[W-1]);
  assign res = !ovf ? sum :
               old[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign res = sum;
`endif

  assign new_wt = mask ? res : old;

endmodule

// File: rtl/sram_synaptic_rmw_ctrl.sv
// Single-outstanding read / read-modify-write initiator for a 1-cycle-latency synaptic SRAM.
// Define SYN_WEIGHT_SAT_EN for saturating lane updates (default: wrap-around).
module sram_synaptic_rmw_ctrl
  import sram_syn_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 8,
  parameter  int DATA_WIDTH   = 32,
  parameter  int WEIGHT_WIDTH = 8,
  localparam int LANES        = lanes_of(DATA_WIDTH, WEIGHT_WIDTH)
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_delta,
  input  logic [LANES-1:0]      req_mask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_old,
  output logic [DATA_WIDTH-1:0] rsp_new,
  output logic                  busy,
  output logic                  CS,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  state_t                state, state_d;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] delta_q;
  logic [LANES-1:0]      mask_q;
  logic [DATA_WIDTH-1:0] old_q, new_q;
  logic [DATA_WIDTH-1:0] upd;
  logic                  accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    syn_lane_update #(.W(WEIGHT_WIDTH)) u_lane (
      .old   (Q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .delta (delta_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .mask  (mask_q[i]),
      .new_wt(upd[i*WEIGHT_WIDTH +: WEIGHT_WIDTH])
    );
  end

  // SRAM strobes are gated by reset so an abort can never leak a write.
  assign req_ready = ~RST & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE);
  assign CS        = ~RST & ((state == RD) | (state == WR));
  assign WE        = ~RST & (state == WR);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RD;
      RD:      state_d = CAP;
      CAP:     state_d = (op_q == OP_UPDATE) ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      op_q      <= OP_READ;
      delta_q   <= '0;
      mask_q    <= '0;
      old_q     <= '0;
      new_q     <= '0;
      A         <= '0;
      D         <= '0;
      rsp_valid <= 1'b0;
      rsp_old   <= '0;
      rsp_new   <= '0;
    end else begin
      state     <= state_d;
      rsp_valid <= (state == RSP);
      if (accept) begin
        op_q    <= req_op;
        delta_q <= req_delta;
        mask_q  <= req_mask;
        A       <= req_addr;
      end
      if (state == CAP) begin
        old_q <= Q;
        new_q <= (op_q == OP_UPDATE) ? upd : Q;
        // D only moves when a write is about to be issued.
        if (op_q == OP_UPDATE) D <= upd;
      end
      if (state == RSP) begin
        rsp_old <= old_q;
        rsp_new <= new_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_synaptic_rmw_ctrl.sv
// Scoreboard bench for sram_synaptic_rmw_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sram_synaptic_rmw_ctrl;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_delta = '0;
  logic [3:0]  req_mask = '0;
  logic        rsp_valid;
  logic [31:0] rsp_old, rsp_new;
  logic        busy, CS, WE;
  logic [7:0]  A;
  logic [31:0] D, Q;

  sram_synaptic_rmw_ctrl dut (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_delta(req_delta), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_old(rsp_old), .rsp_new(rsp_new), .busy(busy),
    .CS(CS), .WE(WE), .A(A), .D(D), .Q(Q)
  );

  always #5 CK = ~CK;

`ifdef SYN_WEIGHT_SAT_EN
  localparam logic [31:0] EXP_UPD = 32'h7F8020FB;
  localparam logic [31:0] EXP_B2B = 32'h13F37F83;
`else
  localparam logic [31:0] EXP_UPD = 32'h807F20FB;
  localparam logic [31:0] EXP_B2B = 32'h13F38283;
`endif

  // SRAM model plus a bench-side preload port
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge CK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (CS) begin
      if (WE) mem[A] <= D;
      else    Q <= mem[A];
    end
  end

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct { logic [31:0] o; logic [31:0] n; } rsp_t;
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];
  logic [31:0] ref_mem [0:255];

  int checks = 0, failures = 0;
  int acc_cyc = 0, last_lat = 0, rsp_cnt = 0, we_cnt = 0;
  logic [31:0] last_wd = '0;

  function automatic logic [31:0] model_upd(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] m);
    logic [31:0] r;
    logic signed [7:0] a, b;
    int s;
    r = o;
    for (int i = 0; i < 4; i++) begin
      a = o[i*8 +: 8];
      b = d[i*8 +: 8];
      s = int'(a) + int'(b);
`ifdef SYN_WEIGHT_SAT_EN
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
`endif
      if (m[i]) r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic monitor_loop();
    rsp_t e;
    wr_t  w;
    forever begin
      @(negedge CK);
      if (!RST) begin
        if (rsp_valid) begin
          rsp_cnt++;
          last_lat = cyc - acc_cyc;
          checks++;
          if (rq.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected old=%h new=%h required=no response", rsp_old, rsp_new);
          end else begin
            e = rq.pop_front();
            if (rsp_old !== e.o || rsp_new !== e.n) begin
              failures++;
              $display("FAIL rsp_data old=%h new=%h required old=%h new=%h",
                       rsp_old, rsp_new, e.o, e.n);
            end
          end
        end
        if (CS && WE) begin
          we_cnt++;
          last_wd = D;
          checks++;
          if (wq.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected A=%h D=%h required=no write", A, D);
          end else begin
            w = wq.pop_front();
            if (A !== w.a || D !== w.d) begin
              failures++;
              $display("FAIL write_data A=%h D=%h required A=%h D=%h", A, D, w.a, w.d);
            end
          end
        end
      end
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(posedge CK); #1;
    pre_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic send(input logic op, input logic [7:0] a, input logic [31:0] dl,
                      input logic [3:0] m, input bit drop);
    bit ok;
    logic [31:0] o, n;
    rsp_t e;
    wr_t  w;
    req_valid = 1'b1; req_op = op; req_addr = a; req_delta = dl; req_mask = m;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CK);
      if (req_ready) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout req_ready=0 required=1 within 20 cycles");
    end else begin
      o = ref_mem[a];
      n = op ? model_upd(o, dl, m) : o;
      e.o = o; e.n = n; rq.push_back(e);
      if (op) begin w.a = a; w.d = n; wq.push_back(w); end
      ref_mem[a] = n;
    end
    @(posedge CK); #1;
    acc_cyc = cyc;
    if (drop) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && (rq.size() != 0 || wq.size() != 0); k++) @(negedge CK);
    @(posedge CK); #1;
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL done_timeout pending_rsp=%0d pending_wr=%0d required=0", rq.size(), wq.size());
      rq.delete(); wq.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_old !== 32'h0 || rsp_new !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs rsp_valid=%b old=%h new=%h busy=%b required 0", rsp_valid, rsp_old, rsp_new, busy);
    end
    checks++;
    if (A !== 8'h0 || D !== 32'h0 || CS !== 1'b0 || WE !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_sram A=%h D=%h CS=%b WE=%b ready=%b required all 0", A, D, CS, WE, req_ready);
    end
    RST = 1'b0;
    @(negedge CK);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release req_ready=%b required=1", req_ready);
    end
  endtask

  task automatic test_read();
    int w0;
    preload(8'd5, 32'h7F801000);
    w0 = we_cnt;
    send(1'b0, 8'd5, 32'hFFFFFFFF, 4'hF, 1'b1);
    wait_done();
    checks++;
    if (last_lat != 3) begin failures++; $display("FAIL read_latency got=%0d required=3", last_lat); end
    checks++;
    if (we_cnt != w0) begin failures++; $display("FAIL read_no_write writes=%0d required=0", we_cnt - w0); end
  endtask

  task automatic test_update_full();
    send(1'b1, 8'd5, 32'h01FF10FB, 4'hF, 1'b1);
    wait_done();
    checks++;
    if (last_lat != 4) begin failures++; $display("FAIL update_latency got=%0d required=4", last_lat); end
    checks++;
    if (last_wd !== EXP_UPD) begin failures++; $display("FAIL update_D got=%h required=%h", last_wd, EXP_UPD); end
    checks++;
    if (mem[5] !== EXP_UPD) begin failures++; $display("FAIL update_mem got=%h required=%h", mem[5], EXP_UPD); end
  endtask

  task automatic test_mask();
    int w0;
    preload(8'd5, 32'h7F801000);
    send(1'b1, 8'd5, 32'h01010101, 4'h5, 1'b1);
    wait_done();
    checks++;
    if (mem[5] !== 32'h7F811001) begin failures++; $display("FAIL mask_mem got=%h required=7f811001", mem[5]); end
    w0 = we_cnt;
    send(1'b1, 8'd5, 32'h12345678, 4'h0, 1'b1);
    wait_done();
    checks++;
    if (we_cnt != w0 + 1 || last_wd !== 32'h7F811001) begin
      failures++;
      $display("FAIL mask_zero_write writes=%0d D=%h required 1 write of 7f811001", we_cnt - w0, last_wd);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int r0;
    preload(8'd7, 32'h10F07F80);
    r0 = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'd7, 32'h01010101, 4'hF, i == 2);
      t[i] = acc_cyc;
    end
    wait_done();
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (t[i] - t[i-1] != 5) begin
        failures++;
        $display("FAIL b2b_spacing gap=%0d required=5", t[i] - t[i-1]);
      end
    end
    checks++;
    if (rsp_cnt - r0 != 3) begin failures++; $display("FAIL b2b_rsp_count got=%0d required=3", rsp_cnt - r0); end
    checks++;
    if (mem[7] !== EXP_B2B) begin failures++; $display("FAIL b2b_mem got=%h required=%h", mem[7], EXP_B2B); end
  endtask

  task automatic test_rst_in_wr();
    int r0, w0;
    preload(8'd5, 32'h7F801000);
    r0 = rsp_cnt; w0 = we_cnt;
    send(1'b1, 8'd5, 32'h01010101, 4'hF, 1'b1);
    @(posedge CK); @(posedge CK); #1;
    RST = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || CS !== 1'b0 || WE !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_gate busy=%b CS=%b WE=%b required busy=1 CS=0 WE=0", busy, CS, WE);
    end
    @(posedge CK); #1;
    RST = 1'b0;
    rq.delete(); wq.delete();
    ref_mem[5] = 32'h7F801000;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_idle ready=%b busy=%b required ready=1 busy=0", req_ready, busy);
    end
    repeat (6) @(posedge CK);
    #1;
    checks++;
    if (rsp_cnt != r0 || we_cnt != w0 || mem[5] !== 32'h7F801000) begin
      failures++;
      $display("FAIL rst_wr_abort rsps=%0d writes=%0d mem=%h required 0 0 7f801000",
               rsp_cnt - r0, we_cnt - w0, mem[5]);
    end
  endtask

  task automatic test_ignore();
    int r0, w0;
    r0 = rsp_cnt; w0 = we_cnt;
    send(1'b0, 8'd5, 32'h0, 4'h0, 1'b1);
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd5; req_delta = 32'h7F7F7F7F; req_mask = 4'hF;
    @(posedge CK); #1;
    @(posedge CK); #1;
    req_valid = 1'b0;
    wait_done();
    repeat (4) @(posedge CK);
    #1;
    checks++;
    if (rsp_cnt - r0 != 1 || we_cnt != w0 || mem[5] !== 32'h7F801000) begin
      failures++;
      $display("FAIL ignore_midop rsps=%0d writes=%0d mem=%h required 1 0 7f801000",
               rsp_cnt - r0, we_cnt - w0, mem[5]);
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_read();
    test_update_full();
    test_mask();
    test_back_to_back();
    test_rst_in_wr();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
